rom_banked_burst: RTL and testbench



---
 rtl/rom_banked_burst.sv | 206 ++++++++++++++++++++
 tb/tb_rom_banked_burst.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_banked_burst.sv
// Banked ROM with a registered valid/ready burst read engine.
// Optional macro ROM_PARITY_EN adds rd_parity and a stored per-word parity check.
module rom_banked_burst #(
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 8,
  parameter int NUM_BANKS  = 3,
  parameter int LEN_W      = 6,
  parameter     INIT_FILE  = "",
  localparam int DEPTH     = NUM_BANKS * BANK_DEPTH,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [LEN_W-1:0]     burst_len,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 rd_last,
  output logic [NUM_BANKS-1:0] bank_sel,
  output logic                 busy,
  output logic                 done,
`ifdef ROM_PARITY_EN
  output logic                 rd_parity,
`endif
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = DATA_W'(21 + 29 * a);
    end
  end

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d, ptr_nx;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic [NUM_BANKS-1:0] bank_sel_q, bank_sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 load;

  logic [NUM_BANKS-1:0] hit;
  logic [DATA_W-1:0]    bank_word [NUM_BANKS];
  logic [DATA_W-1:0]    word;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(b * BANK_DEPTH);
    localparam logic [ADDR_W:0] HI = (ADDR_W+1)'((b + 1) * BANK_DEPTH);
    assign hit[b] = ({1'b0, ptr_q} >= LO) && ({1'b0, ptr_q} < HI);
    assign bank_word[b] = hit[b] ? mem[ptr_q] : '0;
  end

  always_comb begin
    word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      word = word | bank_word[b];
    end
  end

  assign ptr_nx = (ptr_q == LAST_A) ? '0 : ptr_q + ADDR_W'(1);

`ifdef ROM_PARITY_EN
  logic par_mem [DEPTH];
  logic rd_parity_q, rd_parity_d;

  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      par_mem[a] = ^mem[a];
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    bank_sel_d = bank_sel_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    load       = 1'b0;
`ifdef ROM_PARITY_EN
    rd_parity_d = rd_parity_q;
`endif
    if (busy_q && !cs) begin
      state_d    = IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      bank_sel_d = '0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && cs) begin
            if ({1'b0, start_addr} >= DEPTH_L) begin
              err_d = 1'b1;
            end else if (burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              ptr_d   = start_addr;
              rem_d   = burst_len;
              busy_d  = 1'b1;
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          load    = 1'b1;
          state_d = STREAM;
        end
        STREAM: begin
          if (rd_valid_q && rd_ready) begin
            if (rd_last_q) begin
              rd_valid_d = 1'b0;
              rd_last_d  = 1'b0;
              bank_sel_d = '0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              state_d    = IDLE;
            end else begin
              load = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      rd_data_d  = word;
      rd_valid_d = 1'b1;
      rd_last_d  = (rem_q == LEN_W'(1));
      bank_sel_d = hit;
      ptr_d      = ptr_nx;
      rem_d      = rem_q - LEN_W'(1);
`ifdef ROM_PARITY_EN
      rd_parity_d = ^word;
      if ((^word) != par_mem[ptr_q]) err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      bank_sel_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ROM_PARITY_EN
      rd_parity_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      bank_sel_q <= bank_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ROM_PARITY_EN
      rd_parity_q <= rd_parity_d;
`endif
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign bank_sel = bank_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
`ifdef ROM_PARITY_EN
  assign rd_parity = rd_parity_q;
`endif

endmodule

// File: tb/tb_rom_banked_burst.sv
// Directed plus randomized bench for rom_banked_burst.
// Expected words come from the closed-form table formula and address wrap.
module tb_rom_banked_burst;

  localparam int DEPTH = 24;

  logic       clk = 1'b0;
  logic       rst, cs, start, rd_ready;
  logic [4:0] start_addr;
  logic [5:0] burst_len;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, busy, done, err;
  logic [2:0] bank_sel;
`ifdef ROM_PARITY_EN
  logic       rd_parity;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rom_banked_burst dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .bank_sel   (bank_sel),
    .busy       (busy),
    .done       (done),
`ifdef ROM_PARITY_EN
    .rd_parity  (rd_parity),
`endif
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rom_word(input int a);
    return 8'((21 + 29 * a) % 256);
  endfunction

  function automatic logic [2:0] bank_of(input int a);
    return 3'(1 << (a / 8));
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, "_valid"}, rd_valid, 0);
    check({tag, "_last"}, rd_last, 0);
    check({tag, "_bank"}, bank_sel, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Runs one burst; stall_mask bit k holds rd_ready low on beat k,
  // rnd_stall adds random stalls and ignored mid-burst starts.
  task automatic run_burst(input int a, input int n,
                           input logic [31:0] stall_mask,
                           input bit rnd_stall);
    int q[$];
    int k;
    bit rdy;
    for (int i = 0; i < n; i++) q.push_back((a + i) % DEPTH);
    @(negedge clk);
    cs = 1; start = 1; start_addr = 5'(a); burst_len = 6'(n);
    rd_ready = 0;
    @(negedge clk);
    start = 0;
    check("lat_valid", rd_valid, 0);
    check("lat_busy", busy, 1);
    k = 0;
    while (q.size() > 0 && k < 1000) begin
      @(negedge clk);
      check("beat_valid", rd_valid, 1);
      check("beat_data", rd_data, rom_word(q[0]));
      check("beat_bank", bank_sel, bank_of(q[0]));
      check("beat_last", rd_last, q.size() == 1);
      check("beat_done", done, 0);
      check("beat_err", err, 0);
`ifdef ROM_PARITY_EN
      check("beat_par", rd_parity, ^rom_word(q[0]));
`endif
      if (rnd_stall) begin
        rdy = $urandom_range(0, 99) >= 30;
        start = $urandom_range(0, 3) == 0;
        start_addr = 5'd31;
        burst_len = 6'($urandom_range(0, 63));
      end else begin
        rdy = !(k < 32 && stall_mask[k]);
      end
      rd_ready = rdy;
      if (rdy) void'(q.pop_front());
      k++;
    end
    if (q.size() != 0) check("burst_timeout", q.size(), 0);
    @(negedge clk);
    start = 0;
    rd_ready = 0;
    check("end_done", done, 1);
    check("end_err", err, 0);
    idle_outputs("end");
    @(negedge clk);
    check("end_done_clr", done, 0);
  endtask

  initial begin
    rst = 1; cs = 0; start = 0; rd_ready = 0;
    start_addr = '0; burst_len = '0;
    repeat (3) @(negedge clk);
    idle_outputs("rst");
    check("rst_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 0;

    run_burst(0, 3, 32'h0, 0);
    run_burst(6, 4, 32'b110, 0);
    run_burst(22, 4, 32'h0, 0);

    // Out-of-range start address
    @(negedge clk);
    cs = 1; start = 1; start_addr = 5'd24; burst_len = 6'd3;
    @(negedge clk);
    start = 0;
    check("oor_err", err, 1);
    check("oor_done", done, 0);
    check("oor_busy", busy, 0);
    @(negedge clk);
    check("oor_err_clr", err, 0);

    // Zero length
    start = 1; start_addr = 5'd5; burst_len = 6'd0;
    @(negedge clk);
    start = 0;
    check("zlen_done", done, 1);
    check("zlen_err", err, 0);
    idle_outputs("zlen");
    @(negedge clk);
    check("zlen_done_clr", done, 0);
    check("zlen_valid2", rd_valid, 0);

    // Start without chip select
    cs = 0; start = 1; start_addr = 5'd0; burst_len = 6'd3;
    @(negedge clk);
    start = 0;
    idle_outputs("nocs");
    check("nocs_done", done, 0);
    @(negedge clk);
    check("nocs_valid2", rd_valid, 0);
    check("nocs_busy2", busy, 0);

    // Abort with cs low after the second word
    cs = 1; start = 1; start_addr = 5'd10; burst_len = 6'd5;
    rd_ready = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("abt_w1", rd_data, rom_word(10));
    @(negedge clk);
    check("abt_w2", rd_data, rom_word(11));
    cs = 0;
    @(negedge clk);
    idle_outputs("abt");
    check("abt_done", done, 0);
    @(negedge clk);
    check("abt_done2", done, 0);
    cs = 1; rd_ready = 0;

    // Reset in the middle of a burst
    start = 1; start_addr = 5'd3; burst_len = 6'd10; rd_ready = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("mrst_pre_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle_outputs("mrst");
    check("mrst_data", rd_data, 0);
    check("mrst_done", done, 0);
    @(negedge clk);
    check("mrst_done2", done, 0);
    check("mrst_valid2", rd_valid, 0);
    rd_ready = 0;
    run_burst(17, 2, 32'h0, 0);

    for (int t = 0; t < 20; t++) begin
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 40),
                32'h0, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
